mmio_iter_divider: RTL and testbench

//  Parametrised memory-mapped iterative divider peripheral on the MSP430 peripheral bus.

---
 rtl/mmio_div_pkg.sv | 27 ++
 rtl/div_core_unsigned.sv | 57 +++++
 rtl/mmio_iter_divider.sv | 148 ++++++++++++++
 tb/tb_mmio_iter_divider.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_div_pkg.sv
// Shared constants for the memory-mapped iterative divider.
// Holds the register map, the CTRL/STAT bit positions and the FSM encoding.
package mmio_div_pkg;

    localparam logic [13:0] OFF_N    = 14'd0;
    localparam logic [13:0] OFF_D    = 14'd1;
    localparam logic [13:0] OFF_CTRL = 14'd2;
    localparam logic [13:0] OFF_STAT = 14'd3;
    localparam logic [13:0] OFF_Q    = 14'd4;
    localparam logic [13:0] OFF_R    = 14'd5;
    localparam logic [13:0] NUM_REGS = 14'd6;

    localparam int unsigned CTRL_START  = 0;
    localparam int unsigned CTRL_SIGNED = 1;
    localparam int unsigned CTRL_IE     = 2;
    localparam int unsigned CTRL_CLR    = 3;

    localparam int unsigned STAT_BUSY = 0;
    localparam int unsigned STAT_DONE = 1;
    localparam int unsigned STAT_DZ   = 2;

    // Quotient reported on divide-by-zero; truncated to DW bits by the user.
    localparam logic [15:0] DZ_QUOT = 16'hFFFF;

    typedef enum logic [1:0] {StIdle, StLoad, StCalc, StFix} div_state_e;

endpackage

// File: rtl/div_core_unsigned.sv
// DW-cycle restoring unsigned divider: one quotient bit per cycle after start.
// done is high during the final step; q/r are valid from the following cycle.
module div_core_unsigned #(
    parameter int unsigned DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic          busy,
    output logic [DW-1:0] q,
    output logic [DW-1:0] r,
    output logic          done
);

    localparam int unsigned CW = $clog2(DW + 1);

    logic [CW-1:0] cnt_q;
    logic [DW-1:0] quo_q, rem_q, div_q;
    logic [DW:0]   shifted, diff;

    always_comb begin
        shifted = {rem_q, quo_q[DW-1]};
        diff    = shifted - {1'b0, div_q};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            quo_q <= '0;
            rem_q <= '0;
            div_q <= '0;
        end else if (start) begin
            cnt_q <= CW'(DW);
            quo_q <= a;
            rem_q <= '0;
            div_q <= b;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
            // Borrow out means the trial subtraction failed: restore.
            if (diff[DW]) begin
                rem_q <= shifted[DW-1:0];
                quo_q <= {quo_q[DW-2:0], 1'b0};
            end else begin
                rem_q <= diff[DW-1:0];
                quo_q <= {quo_q[DW-2:0], 1'b1};
            end
        end
    end

    assign busy = (cnt_q != '0);
    assign done = (cnt_q == CW'(1));
    assign q    = quo_q;
    assign r    = rem_q;

endmodule

// File: rtl/mmio_iter_divider.sv
// MSP430 peripheral-bus divider: bus decode, operand/result registers,
// sign handling and the IDLE/LOAD/CALC/FIX sequencer around div_core_unsigned.
import mmio_div_pkg::*;

module mmio_iter_divider #(
    parameter logic [13:0] BASE_ADDR = 14'h0A0,
    parameter int unsigned DW        = 16,
    parameter bit          SIGNED_EN = 1'b1
) (
    input  logic        mclk,
    input  logic        puc_rst_n,
    input  logic [13:0] per_addr,
    input  logic [15:0] per_din,
    input  logic        per_en,
    input  logic [1:0]  per_we,
    output logic [15:0] per_dout,
    output logic        irq_div
);

    localparam logic [DW-1:0] DzQ = DZ_QUOT[DW-1:0];

    div_state_e    state_q, state_d;
    logic [DW-1:0] n_q, d_q, q_q, r_q, n_lat_q;
    logic          ctrl_signed_q, ctrl_ie_q, done_q, dz_q;
    logic          sn_q, sd_q, dz_op_q;

    logic [13:0]   offset;
    logic          hit, wr, rd, start_wr, clr_wr, busy;
    logic          mode_signed, n_neg, d_neg;
    logic [DW-1:0] abs_n, abs_d, q_res, r_res;
    logic          core_start, core_busy, core_done;
    logic [DW-1:0] core_q, core_r;

    assign offset   = per_addr - BASE_ADDR;
    assign hit      = per_en && (per_addr >= BASE_ADDR) && (offset < NUM_REGS);
    assign wr       = hit && (per_we == 2'b11);
    assign rd       = hit && (per_we == 2'b00);
    assign start_wr = wr && (offset == OFF_CTRL) && per_din[CTRL_START];
    assign clr_wr   = wr && (offset == OFF_CTRL) && per_din[CTRL_CLR];

    always_comb begin
        mode_signed = SIGNED_EN && ctrl_signed_q;
        n_neg       = mode_signed && n_q[DW-1];
        d_neg       = mode_signed && d_q[DW-1];
        abs_n       = n_neg ? -n_q : n_q;
        abs_d       = d_neg ? -d_q : d_q;
        core_start  = (state_q == StLoad) && (d_q != '0);
        // Quotient sign is the xor of operand signs; remainder follows N.
        q_res       = (sn_q ^ sd_q) ? -core_q : core_q;
        r_res       = sn_q ? -core_r : core_r;
        if (dz_op_q) begin
            q_res = DzQ;
            r_res = n_lat_q;
        end
    end

    div_core_unsigned #(
        .DW(DW)
    ) u_core (
        .clk  (mclk),
        .rst_n(puc_rst_n),
        .start(core_start),
        .a    (abs_n),
        .b    (abs_d),
        .busy (core_busy),
        .q    (core_q),
        .r    (core_r),
        .done (core_done)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (start_wr) state_d = StLoad;
            StLoad: state_d = (d_q == '0) ? StFix : StCalc;
            StCalc: if (core_done) state_d = StFix;
            StFix:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge mclk or negedge puc_rst_n) begin
        if (!puc_rst_n) begin
            state_q       <= StIdle;
            n_q           <= '0;
            d_q           <= '0;
            q_q           <= '0;
            r_q           <= '0;
            n_lat_q       <= '0;
            ctrl_signed_q <= 1'b0;
            ctrl_ie_q     <= 1'b0;
            done_q        <= 1'b0;
            dz_q          <= 1'b0;
            sn_q          <= 1'b0;
            sd_q          <= 1'b0;
            dz_op_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            if (wr && offset == OFF_N) n_q <= per_din[DW-1:0];
            if (wr && offset == OFF_D) d_q <= per_din[DW-1:0];
            if (wr && offset == OFF_CTRL) begin
                ctrl_signed_q <= per_din[CTRL_SIGNED];
                ctrl_ie_q     <= per_din[CTRL_IE];
            end
            if (state_q == StLoad) begin
                sn_q    <= n_neg;
                sd_q    <= d_neg;
                n_lat_q <= n_q;
                dz_op_q <= (d_q == '0);
            end
            if (state_q == StFix) begin
                q_q    <= q_res;
                r_q    <= r_res;
                done_q <= 1'b1;
                dz_q   <= dz_op_q;
            end else if ((start_wr && state_q == StIdle) || clr_wr) begin
                done_q <= 1'b0;
                dz_q   <= 1'b0;
            end
        end
    end

    assign busy    = (state_q != StIdle) || core_busy;
    assign irq_div = done_q && ctrl_ie_q;

    always_comb begin
        per_dout = '0;
        if (rd) begin
            unique case (offset)
                OFF_N:    per_dout[DW-1:0] = n_q;
                OFF_D:    per_dout[DW-1:0] = d_q;
                OFF_CTRL: begin
                    per_dout[CTRL_SIGNED] = ctrl_signed_q;
                    per_dout[CTRL_IE]     = ctrl_ie_q;
                end
                OFF_STAT: begin
                    per_dout[STAT_BUSY] = busy;
                    per_dout[STAT_DONE] = done_q;
                    per_dout[STAT_DZ]   = dz_q;
                end
                OFF_Q:    per_dout[DW-1:0] = q_q;
                OFF_R:    per_dout[DW-1:0] = r_q;
                default:  per_dout = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_iter_divider.sv
// Directed bench for mmio_iter_divider: a 16-bit instance at 0x0A0 and an
// 8-bit instance at 0x0B0 sharing one peripheral bus.
module tb_mmio_iter_divider;

    logic        mclk = 1'b0;
    logic        puc_rst_n = 1'b0;
    logic [13:0] per_addr = '0;
    logic [15:0] per_din = '0;
    logic        per_en = 1'b0;
    logic [1:0]  per_we = '0;
    logic [15:0] dout16, dout8;
    logic        irq16, irq8;

    int checks = 0;
    int errors = 0;

    always #5 mclk = ~mclk;

    mmio_iter_divider #(
        .BASE_ADDR(14'h0A0),
        .DW       (16),
        .SIGNED_EN(1'b1)
    ) dut16 (
        .mclk     (mclk),
        .puc_rst_n(puc_rst_n),
        .per_addr (per_addr),
        .per_din  (per_din),
        .per_en   (per_en),
        .per_we   (per_we),
        .per_dout (dout16),
        .irq_div  (irq16)
    );

    mmio_iter_divider #(
        .BASE_ADDR(14'h0B0),
        .DW       (8),
        .SIGNED_EN(1'b1)
    ) dut8 (
        .mclk     (mclk),
        .puc_rst_n(puc_rst_n),
        .per_addr (per_addr),
        .per_din  (per_din),
        .per_en   (per_en),
        .per_we   (per_we),
        .per_dout (dout8),
        .irq_div  (irq8)
    );

    typedef struct {
        logic [15:0] n, d, ctrl, q, r, stat;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge mclk);
        #1;
    endtask

    // Bus write held for one cycle; returns 1 ns after the committing edge.
    task automatic wr(input logic [13:0] a, input logic [15:0] d, input logic [1:0] we);
        per_en = 1'b1;
        per_addr = a;
        per_din = d;
        per_we = we;
        @(posedge mclk);
        #1;
        per_en = 1'b0;
        per_we = 2'b00;
    endtask

    task automatic rd(input logic [13:0] a, output logic [15:0] v);
        per_en = 1'b1;
        per_we = 2'b00;
        per_addr = a;
        #1;
        v = (a >= 14'h0B0) ? dout8 : dout16;
        per_en = 1'b0;
    endtask

    task automatic wait_done(input logic [13:0] base);
        logic [15:0] s;
        bit ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            rd(base + 14'd3, s);
            if (s[1]) ok = 1'b1;
            else tick(1);
        end
        chk("done_timeout", {15'd0, ok}, 16'd1);
    endtask

    initial begin
        logic [15:0] v;

        vecs[0] = '{16'd1000, 16'd7,    16'h1, 16'd142,  16'd6,    16'h2};
        vecs[1] = '{16'hFF9C, 16'd7,    16'h3, 16'hFFF2, 16'hFFFE, 16'h2};
        vecs[2] = '{16'h8000, 16'hFFFF, 16'h3, 16'h8000, 16'h0000, 16'h2};
        vecs[3] = '{16'd55,   16'd0,    16'h1, 16'hFFFF, 16'd55,   16'h6};
        vecs[4] = '{16'd100,  16'hFFF9, 16'h3, 16'hFFF2, 16'd2,    16'h2};
        vecs[5] = '{16'hFF9C, 16'hFFF9, 16'h3, 16'd14,   16'hFFFE, 16'h2};
        vecs[6] = '{16'hFF9C, 16'd7,    16'h1, 16'h2484, 16'd0,    16'h2};
        vecs[7] = '{16'hFFFF, 16'd1,    16'h1, 16'hFFFF, 16'd0,    16'h2};
        vecs[8] = '{16'd5,    16'd9,    16'h1, 16'd0,    16'd5,    16'h2};
        vecs[9] = '{16'hFFFB, 16'd0,    16'h3, 16'hFFFF, 16'hFFFB, 16'h6};

        #23 puc_rst_n = 1'b1;
        tick(1);

        // Reset state
        for (int i = 0; i < 6; i++) begin
            rd(14'h0A0 + 14'(i), v);
            chk($sformatf("reset_reg%0d", i), v, 16'h0);
        end
        chk("reset_irq", {15'd0, irq16}, 16'h0);
        tick(1);

        // Table of divisions
        foreach (vecs[k]) begin
            wr(14'h0A0, vecs[k].n, 2'b11);
            wr(14'h0A1, vecs[k].d, 2'b11);
            wr(14'h0A2, vecs[k].ctrl, 2'b11);
            wait_done(14'h0A0);
            rd(14'h0A4, v); chk($sformatf("vec%0d_q", k), v, vecs[k].q);
            rd(14'h0A5, v); chk($sformatf("vec%0d_r", k), v, vecs[k].r);
            rd(14'h0A3, v); chk($sformatf("vec%0d_stat", k), v, vecs[k].stat);
            tick(1);
        end

        // Latency: 1000/7, START in cycle 0
        wr(14'h0A0, 16'd1000, 2'b11);
        wr(14'h0A1, 16'd7, 2'b11);
        wr(14'h0A2, 16'h1, 2'b11);
        rd(14'h0A3, v); chk("lat_c1_stat", v, 16'h1);
        rd(14'h0A2, v); chk("ctrl_start_reads0", v, 16'h0);
        tick(17);
        rd(14'h0A3, v); chk("lat_c18_stat", v, 16'h1);
        tick(1);
        rd(14'h0A3, v); chk("lat_c19_stat", v, 16'h2);
        rd(14'h0A4, v); chk("lat_q", v, 16'd142);
        rd(14'h0A5, v); chk("lat_r", v, 16'd6);
        wr(14'h0A4, 16'h1234, 2'b11);
        wr(14'h0A3, 16'h0000, 2'b11);
        rd(14'h0A4, v); chk("q_write_ignored", v, 16'd142);
        rd(14'h0A3, v); chk("stat_write_ignored", v, 16'h2);
        rd(14'h0A6, v); chk("unmapped_read", v, 16'h0);

        // Divide by zero with IE, then CLR keeping IE
        wr(14'h0A0, 16'd55, 2'b11);
        wr(14'h0A1, 16'd0, 2'b11);
        wr(14'h0A2, 16'h5, 2'b11);
        rd(14'h0A3, v); chk("dz_c1_stat", v, 16'h1);
        tick(1);
        rd(14'h0A3, v); chk("dz_c2_stat", v, 16'h1);
        tick(1);
        rd(14'h0A3, v); chk("dz_c3_stat", v, 16'h6);
        chk("dz_irq", {15'd0, irq16}, 16'h1);
        rd(14'h0A4, v); chk("dz_q", v, 16'hFFFF);
        rd(14'h0A5, v); chk("dz_r", v, 16'd55);
        wr(14'h0A2, 16'hC, 2'b11);
        rd(14'h0A3, v); chk("clr_stat", v, 16'h0);
        chk("clr_irq", {15'd0, irq16}, 16'h0);
        rd(14'h0A2, v); chk("clr_ctrl_ie", v, 16'h4);

        // START while busy is ignored; N update does not affect running op
        wr(14'h0A0, 16'd65000, 2'b11);
        wr(14'h0A1, 16'd3, 2'b11);
        wr(14'h0A2, 16'h1, 2'b11);
        tick(4);
        wr(14'h0A0, 16'd1, 2'b11);
        wr(14'h0A2, 16'h1, 2'b11);
        tick(11);
        rd(14'h0A3, v); chk("busy_c18_stat", v, 16'h1);
        tick(1);
        rd(14'h0A3, v); chk("busy_c19_stat", v, 16'h2);
        rd(14'h0A4, v); chk("busy_q", v, 16'd21666);
        rd(14'h0A5, v); chk("busy_r", v, 16'd2);
        rd(14'h0A0, v); chk("busy_n_updated", v, 16'd1);
        tick(20);
        rd(14'h0A3, v); chk("no_restart_stat", v, 16'h2);

        // Interrupt, then reset mid-calculation
        wr(14'h0A0, 16'd200, 2'b11);
        wr(14'h0A1, 16'd10, 2'b11);
        wr(14'h0A2, 16'h5, 2'b11);
        tick(17);
        chk("irq_c18", {15'd0, irq16}, 16'h0);
        tick(1);
        chk("irq_c19", {15'd0, irq16}, 16'h1);
        rd(14'h0A4, v); chk("irq_q", v, 16'd20);
        rd(14'h0A5, v); chk("irq_r", v, 16'd0);
        wr(14'h0A2, 16'h5, 2'b11);
        tick(5);
        rd(14'h0A3, v); chk("midcalc_stat", v, 16'h1);
        puc_rst_n = 1'b0;
        #1;
        chk("rst_irq", {15'd0, irq16}, 16'h0);
        for (int i = 0; i < 6; i++) begin
            rd(14'h0A0 + 14'(i), v);
            chk($sformatf("rst_reg%0d", i), v, 16'h0);
        end
        puc_rst_n = 1'b1;
        tick(1);
        tick(30);
        rd(14'h0A3, v); chk("after_rst_idle", v, 16'h0);

        // 8-bit instance: 250/16, latency DW+3 = 11
        wr(14'h0B0, 16'd250, 2'b11);
        wr(14'h0B1, 16'd16, 2'b11);
        wr(14'h0B2, 16'h1, 2'b11);
        tick(9);
        rd(14'h0B3, v); chk("dw8_c10_stat", v, 16'h1);
        tick(1);
        rd(14'h0B3, v); chk("dw8_c11_stat", v, 16'h2);
        rd(14'h0B4, v); chk("dw8_q", v, 16'd15);
        chk("dw8_other_dout", dout16, 16'h0);
        rd(14'h0B5, v); chk("dw8_r", v, 16'd10);
        wr(14'h0B0, 16'h0077, 2'b01);
        rd(14'h0B0, v); chk("dw8_byte_write_ignored", v, 16'd250);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
